// File: rtl/button_click_decoder.sv
// Groups release pulses that arrive within WINDOW_CYCLES of each other into one click event.
// Latency: strobe WINDOW_CYCLES edges after the last pulse, or on the edge of the MAX_CLICKS-th pulse.
// Backpressure: none; every pulse is consumed and strobes are fire-and-forget single cycles.
//
// Ports:
//   clk           - system clock, all state on rising edge
//   reset_n       - asynchronous active-low reset
//   enable        - decoder enable; dropping it abandons an open group without a strobe
//   release_pulse - one-cycle pulse from the release-edge detector
//   click_valid   - one-cycle strobe when a group closes
//   click_count   - click count of the last closed group, held until the next strobe
//   single_click  - one-cycle pulse alongside click_valid when the count is 1
//   double_click  - one-cycle pulse alongside click_valid when the count is 2
//   busy          - high while a group is open
module button_click_decoder #(
  parameter  int WINDOW_CYCLES = 5000000,
  parameter  int MAX_CLICKS    = 3,
  localparam int TW            = $clog2(WINDOW_CYCLES),
  localparam int CW            = $clog2(MAX_CLICKS + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  input  logic          release_pulse,
  output logic          click_valid,
  output logic [CW-1:0] click_count,
  output logic          single_click,
  output logic          double_click,
  output logic          busy
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam logic [TW-1:0] TIMER_LAST = TW'(WINDOW_CYCLES - 1);
  localparam logic [CW-1:0] COUNT_LAST = CW'(MAX_CLICKS - 1);
  localparam logic [CW-1:0] COUNT_MAX  = CW'(MAX_CLICKS);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
  localparam logic [CW-1:0] COUNT_TWO  = CW'(2);

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [CW-1:0] count_q, count_d;
  logic          click_valid_q, click_valid_d;
  logic [CW-1:0] click_count_q, click_count_d;
  logic          single_q, single_d;
  logic          double_q, double_d;

  // Group close request from the FSM and the count it reports.
  logic          strobe;
  logic [CW-1:0] strobe_cnt;

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    count_d       = count_q;
    strobe        = 1'b0;
    strobe_cnt    = count_q;

    unique case (state_q)
      IDLE: begin
        // A pulse seen while disabled is simply dropped.
        if (enable && release_pulse) begin
          state_d = WAIT;
          count_d = COUNT_ONE;
          timer_d = '0;
        end
      end
      WAIT: begin
        if (!enable) begin
          // Abandon: a coinciding pulse or timeout is deliberately swallowed.
          state_d = IDLE;
          count_d = '0;
          timer_d = '0;
        end else if (release_pulse) begin
          // A pulse always beats a coinciding timeout and restarts the window.
          if (count_q == COUNT_LAST) begin
            strobe     = 1'b1;
            strobe_cnt = COUNT_MAX;
            state_d    = IDLE;
            count_d    = '0;
            timer_d    = '0;
          end else begin
            count_d = count_q + COUNT_ONE;
            timer_d = '0;
          end
        end else if (timer_q == TIMER_LAST) begin
          strobe     = 1'b1;
          strobe_cnt = count_q;
          state_d    = IDLE;
          count_d    = '0;
          timer_d    = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
        timer_d = '0;
      end
    endcase
  end

  // Output decode: the held count only moves when a group closes.
  always_comb begin
    click_valid_d = strobe;
    click_count_d = strobe ? strobe_cnt : click_count_q;
    single_d      = strobe && (strobe_cnt == COUNT_ONE);
    double_d      = strobe && (strobe_cnt == COUNT_TWO);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      count_q       <= '0;
      click_valid_q <= 1'b0;
      click_count_q <= '0;
      single_q      <= 1'b0;
      double_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      count_q       <= count_d;
      click_valid_q <= click_valid_d;
      click_count_q <= click_count_d;
      single_q      <= single_d;
      double_q      <= double_d;
    end
  end

  assign click_valid  = click_valid_q;
  assign click_count  = click_count_q;
  assign single_click = single_q;
  assign double_click = double_q;
  assign busy         = (state_q == WAIT);

endmodule

// File: tb/tb_button_click_decoder.sv
// Directed bench for button_click_decoder with WINDOW_CYCLES=8, MAX_CLICKS=3.
// Edges are numbered from 1 within each scenario; reset is held over edges 1..3.
// Expected strobes are queued per scenario and popped whenever click_valid is seen.
module tb_button_click_decoder;

  localparam int WIN = 8;
  localparam int MAXC = 3;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic       release_pulse;
  logic       click_valid;
  logic [1:0] click_count;
  logic       single_click;
  logic       double_click;
  logic       busy;

  typedef struct {
    int   edge_no;
    int   cnt;
    logic sgl;
    logic dbl;
  } exp_t;

  exp_t sb[$];
  int   edge_no;
  int   n_cmp;
  int   n_bad;

  button_click_decoder #(
    .WINDOW_CYCLES(WIN),
    .MAX_CLICKS   (MAXC)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .release_pulse(release_pulse),
    .click_valid  (click_valid),
    .click_count  (click_count),
    .single_click (single_click),
    .double_click (double_click),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d (edge %0d)", tag, obs, exp, edge_no);
    end
  endtask

  task automatic expect_strobe(input int e, input int c, input logic s, input logic d);
    exp_t x;
    x.edge_no = e;
    x.cnt     = c;
    x.sgl     = s;
    x.dbl     = d;
    sb.push_back(x);
  endtask

  // Drive one cycle of stimulus, advance one edge, then sample 1 time unit later.
  task automatic tick(input logic en, input logic pl);
    exp_t x;
    enable        = en;
    release_pulse = pl;
    @(posedge clk);
    edge_no++;
    #1;
    if (click_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $error("FAIL unexpected_strobe observed count=%0d expected no strobe (edge %0d)",
               click_count, edge_no);
      end else begin
        x = sb.pop_front();
        check("strobe_edge", 32'(edge_no), 32'(x.edge_no));
        check("strobe_count", 32'(click_count), 32'(x.cnt));
        check("strobe_single", 32'(single_click), 32'(x.sgl));
        check("strobe_double", 32'(double_click), 32'(x.dbl));
      end
    end else begin
      check("decode_without_valid", 32'({single_click, double_click}), 32'(0));
    end
  endtask

  task automatic do_reset();
    sb.delete();
    edge_no       = 0;
    reset_n       = 1'b0;
    enable        = 1'b0;
    release_pulse = 1'b0;
    repeat (3) tick(1'b0, 1'b0);
    reset_n = 1'b1;
  endtask

  task automatic end_scenario(input string tag);
    check(tag, 32'(sb.size()), 32'(0));
    sb.delete();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;

    // 1: reset values, then a single click at edge 10 closing at edge 18.
    do_reset();
    check("reset_valid", 32'(click_valid), 32'(0));
    check("reset_count", 32'(click_count), 32'(0));
    check("reset_single", 32'(single_click), 32'(0));
    check("reset_double", 32'(double_click), 32'(0));
    check("reset_busy", 32'(busy), 32'(0));
    expect_strobe(18, 1, 1'b1, 1'b0);
    for (int e = 4; e <= 25; e++) begin
      tick(1'b1, e == 10);
      if (e == 9)  check("s1_busy_before", 32'(busy), 32'(0));
      if (e == 10) check("s1_busy_open", 32'(busy), 32'(1));
      if (e == 17) check("s1_busy_late", 32'(busy), 32'(1));
      if (e == 18) check("s1_busy_closed", 32'(busy), 32'(0));
    end
    check("s1_count_held", 32'(click_count), 32'(1));
    end_scenario("s1_missing_strobe");

    // 2: double click, pulses at 10 and 15, close at 23.
    do_reset();
    expect_strobe(23, 2, 1'b0, 1'b1);
    for (int e = 4; e <= 30; e++) tick(1'b1, (e == 10) || (e == 15));
    check("s2_count_held", 32'(click_count), 32'(2));
    end_scenario("s2_missing_strobe");

    // 3: max clicks close immediately at 13; pulse at 14 opens a fresh group of one.
    do_reset();
    expect_strobe(13, 3, 1'b0, 1'b0);
    expect_strobe(22, 1, 1'b1, 1'b0);
    for (int e = 4; e <= 28; e++) begin
      tick(1'b1, (e == 10) || (e == 12) || (e == 13) || (e == 14));
      if (e == 13) check("s3_busy_after_max", 32'(busy), 32'(0));
      if (e == 14) begin
        check("s3_busy_new_group", 32'(busy), 32'(1));
        check("s3_count_held", 32'(click_count), 32'(3));
      end
    end
    end_scenario("s3_missing_strobe");

    // 4: pulse coinciding with timeout at 18 is counted; close at 26.
    do_reset();
    expect_strobe(26, 2, 1'b0, 1'b1);
    for (int e = 4; e <= 32; e++) begin
      tick(1'b1, (e == 10) || (e == 18));
      if (e == 18) check("s4_busy_at_coincide", 32'(busy), 32'(1));
    end
    end_scenario("s4_missing_strobe");

    // 5a: enable dropped at 14 abandons the group; a pulse while disabled in IDLE is ignored.
    do_reset();
    for (int e = 4; e <= 40; e++) begin
      tick(!((e == 14) || (e == 15)), (e == 10) || (e == 15));
      if (e == 14) check("s5a_busy_abandon", 32'(busy), 32'(0));
      if (e == 15) check("s5a_busy_ignored", 32'(busy), 32'(0));
    end
    check("s5a_busy_end", 32'(busy), 32'(0));
    check("s5a_count_end", 32'(click_count), 32'(0));
    end_scenario("s5a_queue_empty");

    // 5b: asynchronous reset mid-group discards it.
    do_reset();
    for (int e = 4; e <= 11; e++) tick(1'b1, e == 10);
    check("s5b_busy_before_reset", 32'(busy), 32'(1));
    reset_n = 1'b0;
    #1;
    check("s5b_busy_async_reset", 32'(busy), 32'(0));
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    reset_n = 1'b1;
    for (int e = 14; e <= 40; e++) tick(1'b1, 1'b0);
    check("s5b_busy_end", 32'(busy), 32'(0));
    check("s5b_count_end", 32'(click_count), 32'(0));
    end_scenario("s5b_queue_empty");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/button_click_decoder.md
Name: button_click_decoder

Overview:
- Sits directly downstream of the button release-edge detector.
- Consumes its one-cycle release pulse and groups pulses that arrive within a programmable inter-click window into a single click event.
- Reports the event as single, double or up to MAX_CLICKS-fold clicks to the game/menu control logic.
- Provides a single-cycle event strobe plus a held click count.

Parameters:
WINDOW_CYCLES, 5000000, max clk cycles allowed between consecutive release pulses of one click group (>=2)
MAX_CLICKS, 3, click count at which the group is closed immediately (>=2)
TW, $clog2(WINDOW_CYCLES), window timer width (derived, not overridden)
CW, $clog2(MAX_CLICKS+1), click count width (derived, not overridden)

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
enable  input  1  decoder enable; low abandons any open group
release_pulse  input  1  one-cycle pulse from release-edge detector
click_valid  output  1  one-cycle strobe, group closed
click_count  output  CW  clicks in last closed group, held until next click_valid
single_click  output  1  one-cycle pulse, click_valid with count==1
double_click  output  1  one-cycle pulse, click_valid with count==2
busy  output  1  high while a group is open (state WAIT)

Behaviour:
- Reset (reset_n low, async): state=IDLE, timer=0, count=0.
- Reset outputs: click_valid=0, click_count=0, single_click=0, double_click=0, busy=0.
- Reset can occur mid-group: the group is discarded and no strobe is issued after release.
- All outputs are registered. busy = (state==WAIT).
- Edge k below means the rising edge that samples an accepted pulse.
- IDLE:
  - enable=1 and release_pulse=1 → WAIT, count=1, timer=0.
  - If MAX_CLICKS were 1 this would close immediately; that is excluded by the MAX_CLICKS>=2 rule.
- WAIT, enable=0:
  - → IDLE, count=0.
  - No strobe, even if a pulse or a timeout coincides.
- WAIT, enable=1, release_pulse=1, count<MAX_CLICKS-1: count+=1, timer=0, stay WAIT.
- WAIT, enable=1, release_pulse=1, count==MAX_CLICKS-1:
  - At that same edge: click_valid=1, click_count=MAX_CLICKS, → IDLE.
  - Immediate close, no window wait.
- WAIT, enable=1, release_pulse=0, timer<WINDOW_CYCLES-1: timer+=1.
- WAIT, enable=1, release_pulse=0, timer==WINDOW_CYCLES-1:
  - click_valid=1, click_count=count, → IDLE.
  - Net effect: strobe rises at edge k+WINDOW_CYCLES after the last accepted pulse.
- Simultaneous pulse and timeout: the pulse wins. It is counted, the timer restarts, and no strobe is issued.
- Back-to-back pulses on consecutive cycles are each counted. No minimum spacing is assumed.
- Pulse in the first IDLE cycle after a strobe starts a new group (count=1). Strobes are never merged.
- single_click and double_click are asserted on the same edge as click_valid and decoded from the new count.
- click_valid and the decoded pulses deassert on the next edge.
- release_pulse while enable=0 in IDLE is ignored.
- Timer never exceeds WINDOW_CYCLES-1. Count never exceeds MAX_CLICKS. No wrap-around is possible.

Test Plan (WINDOW_CYCLES=8, MAX_CLICKS=3):
1. Reset and one pulse at edge 10:
   - Stimulus: hold reset_n low 3 cycles, release, enable=1, pulse sampled at edge 10.
   - Required: busy=1 from edge 10; click_valid/single_click high only after edge 18; click_count=1; busy=0 after edge 18.
2. Double click:
   - Stimulus: pulses at edges 10 and 15.
   - Required: no strobe at 18; strobe after edge 23 with click_count=2 and double_click=1, single_click=0.
3. Max clicks:
   - Stimulus: pulses at edges 10, 12, 13.
   - Required: strobe after edge 13 with click_count=3, both decoded pulses 0. Pulse at edge 14 opens a new group (busy=1, count=1).
4. Pulse coinciding with timeout:
   - Stimulus: pulses at edges 10 and 18.
   - Required: no strobe at 18; strobe after edge 26 with click_count=2.
5. Abandon:
   - Stimulus: pulse at edge 10, enable=0 at edge 14, re-enable at edge 16; separately, reset_n low at edge 12 after a pulse at edge 10.
   - Required: click_valid stays 0 through edge 40 in both cases; busy=0; click_count keeps its prior value (0 after reset).
